// File: rtl/clock_pkg.sv
// Shared mode encoding and time limits for the alarm clock controller.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        ALM_HR  = 3'd3,
        ALM_MIN = 3'd4
    } mode_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            SET_MIN: return ALM_HR;
            ALM_HR:  return ALM_MIN;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_btn_edge.sv
// Registered rising-edge detector for a synchronised, debounced button level.
module btn_edge (
    input  logic Clk,
    input  logic Clr,
    input  logic sig,
    output logic rise
);

    logic level_p1;
    logic primed_p1;

    // primed_p1 masks the first sample after reset so a button held through reset is not an edge
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            level_p1  <= 1'b0;
            primed_p1 <= 1'b0;
            rise      <= 1'b0;
        end else begin
            level_p1  <= sig;
            primed_p1 <= 1'b1;
            rise      <= sig & ~level_p1 & primed_p1;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode FSM, counter pulse sequencing and alarm control for the alarm clock.
// Optional feature macro: AUTO_REPEAT_EN (held increment auto-repeat in set states).
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int ALARM_SECS = 60,
    parameter int HOLD_TICKS = 2
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Tick,
    input  logic       BtnMode,
    input  logic       BtnInc,
    input  logic       AlarmArm,
    input  logic [5:0] SecCount,
    input  logic [5:0] MinCount,
    input  logic [4:0] HrCount,
    input  logic [5:0] AlmMin,
    input  logic [4:0] AlmHr,
    output logic       SecUp,
    output logic       MinUp,
    output logic       HrUp,
    output logic       AlmMinUp,
    output logic       AlmHrUp,
    output logic       SecClrN,
    output logic       Alarm,
    output logic [2:0] Mode
);

    localparam int            CNT_W      = $clog2(ALARM_SECS + 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_SECS);

    mode_t            state, state_nxt;
    logic [CNT_W-1:0] alm_cnt, alm_cnt_nxt;
    logic             mode_rise, inc_rise;
    logic             alarm_match;
    logic             sec_up_nxt, min_up_nxt, hr_up_nxt;
    logic             alm_min_up_nxt, alm_hr_up_nxt;
    logic             sec_clr_n_nxt, alarm_nxt;

`ifdef AUTO_REPEAT_EN
    localparam int               HOLD_W   = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_TICKS);
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
`endif

    btn_edge u_mode_edge (
        .Clk  (Clk),
        .Clr  (Clr),
        .sig  (BtnMode),
        .rise (mode_rise)
    );

    btn_edge u_inc_edge (
        .Clk  (Clk),
        .Clr  (Clr),
        .sig  (BtnInc),
        .rise (inc_rise)
    );

    assign alarm_match = AlarmArm && (HrCount == AlmHr) && (MinCount == AlmMin) && (SecCount == '0);
    assign Mode        = state;

    always_comb begin
        state_nxt      = state;
        sec_up_nxt     = 1'b0;
        min_up_nxt     = 1'b0;
        hr_up_nxt      = 1'b0;
        alm_min_up_nxt = 1'b0;
        alm_hr_up_nxt  = 1'b0;
        sec_clr_n_nxt  = 1'b1;
        alarm_nxt      = Alarm;
        alm_cnt_nxt    = alm_cnt;

        if (mode_rise) begin
            state_nxt     = next_mode(state);
            sec_clr_n_nxt = (state != SET_MIN);
        end

        if (state == RUN && Tick) begin
            sec_up_nxt = 1'b1;
            if (SecCount == SEC_MAX) begin
                min_up_nxt = 1'b1;
                hr_up_nxt  = (MinCount == MIN_MAX);
            end
        end

        // A mode change in the same cycle swallows the increment
        if (inc_rise && !mode_rise) begin
            case (state)
                SET_HR:  hr_up_nxt      = 1'b1;
                SET_MIN: min_up_nxt     = 1'b1;
                ALM_HR:  alm_hr_up_nxt  = 1'b1;
                ALM_MIN: alm_min_up_nxt = 1'b1;
                default: ;
            endcase
        end

`ifdef AUTO_REPEAT_EN
        hold_nxt = hold_cnt;
        if (state == RUN || mode_rise || !BtnInc || inc_rise) begin
            hold_nxt = '0;
        end else if (Tick) begin
            if (hold_cnt < HOLD_LIM) begin
                hold_nxt = hold_cnt + HOLD_W'(1);
            end else begin
                case (state)
                    SET_HR:  hr_up_nxt      = 1'b1;
                    SET_MIN: min_up_nxt     = 1'b1;
                    ALM_HR:  alm_hr_up_nxt  = 1'b1;
                    ALM_MIN: alm_min_up_nxt = 1'b1;
                    default: ;
                endcase
            end
        end
`endif

        // Dismiss sources beat a fresh trigger; a trigger reloads an already-running countdown
        if (mode_rise || !AlarmArm || (state == RUN && inc_rise)) begin
            alarm_nxt   = 1'b0;
            alm_cnt_nxt = '0;
        end else if (state == RUN && Tick && alarm_match) begin
            alarm_nxt   = 1'b1;
            alm_cnt_nxt = ALARM_LOAD;
        end else if (Alarm && Tick) begin
            alm_cnt_nxt = alm_cnt - CNT_W'(1);
            if (alm_cnt == CNT_W'(1)) begin
                alarm_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state    <= RUN;
            SecUp    <= 1'b0;
            MinUp    <= 1'b0;
            HrUp     <= 1'b0;
            AlmMinUp <= 1'b0;
            AlmHrUp  <= 1'b0;
            SecClrN  <= 1'b1;
            Alarm    <= 1'b0;
            alm_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            SecUp    <= sec_up_nxt;
            MinUp    <= min_up_nxt;
            HrUp     <= hr_up_nxt;
            AlmMinUp <= alm_min_up_nxt;
            AlmHrUp  <= alm_hr_up_nxt;
            SecClrN  <= sec_clr_n_nxt;
            Alarm    <= alarm_nxt;
            alm_cnt  <= alm_cnt_nxt;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_nxt;
        end
    end
`endif

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode and sequencing controller for the alarm clock datapath. It drives the `Up` pulses of the seconds, minutes and hours counters and of the alarm minute/hour counters. In RUN it cascades the 1 Hz tick into carries. In the set states it steers the increment button to one counter. It also compares current time against alarm time to raise and retire the alarm output.

## Interface
Parameters:
- ALARM_SECS, 60: number of ticks the alarm stays asserted if not dismissed.
- HOLD_TICKS, 2: ticks BtnInc must be held before auto-repeat starts (AUTO_REPEAT_EN only).

Ports:
- Clk  in  1  system clock.
- Clr  in  1  reset, asynchronous, active-low.
- Tick  in  1  one-Clk-cycle pulse at 1 Hz.
- BtnMode  in  1  debounced, synchronised mode button, level.
- BtnInc  in  1  debounced, synchronised increment button, level.
- AlarmArm  in  1  alarm enable switch, level.
- SecCount  in  6  seconds counter value, 0–59.
- MinCount  in  6  minutes counter value, 0–59.
- HrCount  in  5  hours counter value, 0–23.
- AlmMin  in  6  alarm minutes value.
- AlmHr  in  5  alarm hours value.
- SecUp, MinUp, HrUp  out  1  one-cycle count pulses to the time counters.
- AlmMinUp, AlmHrUp  out  1  one-cycle count pulses to the alarm counters.
- SecClrN  out  1  active-low one-cycle synchronous clear request for the seconds counter.
- Alarm  out  1  alarm sounding.
- Mode  out  3  current state encoding, for display blanking and blinking.

## Operation
- FSM states: RUN, SET_HR, SET_MIN, ALM_HR, ALM_MIN.
- A rising edge of BtnMode advances the state RUN→SET_HR→SET_MIN→ALM_HR→ALM_MIN→RUN.
- Rising edges are detected from the previous-cycle sample.
- RUN:
  - On Tick, pulse SecUp.
  - If SecCount==59, also pulse MinUp.
  - If SecCount==59 and MinCount==59, also pulse HrUp.
  - All pulses fire in the same cycle; the counters perform their own wrap.
- Set states:
  - Tick is ignored, so time is frozen.
  - A BtnInc rising edge pulses exactly one output: HrUp, MinUp, AlmHrUp or AlmMinUp respectively.
- On the transition out of SET_MIN, SecClrN is driven low for one cycle, so seconds restart at 0.
- Alarm trigger:
  - Condition: in RUN, AlarmArm=1, HrCount==AlmHr, MinCount==AlmMin and SecCount==0, sampled on a Tick cycle.
  - Effect: Alarm is set and a tick counter loads ALARM_SECS.
- Alarm clears on the first of:
  - BtnInc rising edge in RUN (dismiss, no counter pulse);
  - counter reaching 0 on Tick;
  - AlarmArm=0;
  - any BtnMode edge.
- Simultaneous BtnMode and BtnInc edges in one cycle: the mode change wins and the increment is dropped.
- Tick and a BtnInc edge in the same RUN cycle: the tick is processed and the alarm is dismissed.
- Alarm does not re-trigger within the same matched minute after dismissal, because the match requires SecCount==0.

## Timing
- All outputs are registered. Each pulse asserts in the cycle after the causing Tick or button edge and lasts exactly one Clk cycle.
- Button-to-pulse latency is 2 cycles: edge-detect register, then output register.
- Reset (Clr low, asynchronous):
  - state=RUN, Mode=RUN encoding;
  - all Up outputs=0, SecClrN=1, Alarm=0;
  - alarm counter=0, edge registers=0.
- Reset mid-operation aborts any pending pulse; the first edge after release is not counted if the button is already held.
- Counters consume the pulses with Enable tied 1 and LD tied 0 at the top level.

## Configuration
- AUTO_REPEAT_EN:
  - Defined: in set states, holding BtnInc for HOLD_TICKS ticks after its rising edge produces one extra Up pulse on every subsequent Tick until release. The hold counter resets on release or on a mode change.
  - Undefined: only rising edges count, and HOLD_TICKS is unused.

## Structure
- Shared package clock_pkg holds:
  - the state enum/encoding for Mode;
  - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
- Sub-module btn_edge (registered rising-edge detector) is instantiated twice, for BtnMode and BtnInc.

## Test plan
- RUN, SecCount=59, MinCount=59, HrCount=23, Tick → SecUp, MinUp and HrUp all high in the same single cycle.
- Three BtnMode edges from RUN → Mode=ALM_HR; BtnInc edge → only AlmHrUp pulses, once.
- In SET_MIN, BtnMode edge → state goes to ALM_HR and SecClrN is low for exactly one cycle; Tick in SET_HR produces no SecUp.
- AlarmArm=1, AlmHr=7, AlmMin=30, time 07:30:00 on Tick → Alarm=1; with no dismiss it is 0 after 60 ticks; a BtnInc edge at tick 5 clears it immediately.
- BtnMode and BtnInc rising in the same cycle in SET_HR → Mode=SET_MIN and no HrUp.
- With AUTO_REPEAT_EN, HOLD_TICKS=2, hold BtnInc in SET_MIN for 5 ticks → 4 MinUp pulses (1 edge + 3 repeats).
- Clr asserted mid-alarm → Alarm=0 and Mode=RUN immediately, without waiting for Clk.
